// File: rtl/or_gate.sv
// Bitwise two-input OR with a combinational result, registered copy,
// registered reduction flag and an optional sticky accumulator.
module or_gate #(
   parameter int unsigned WIDTH     = 1,
   parameter bit          STICKY_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out,
   input  logic             en,
   output logic [WIDTH-1:0] out_q,
   output logic             any_q,
   input  logic             sticky_clr,
   output logic [WIDTH-1:0] sticky_q
);

   assign out = a | b;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q <= '0;
         any_q <= 1'b0;
      end else if (en) begin
         out_q <= out;
         any_q <= |out;
      end
   end

   generate
      if (STICKY_EN) begin : g_sticky
         // Clear and capture on the same edge keep the new data.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               sticky_q <= '0;
            end else if (sticky_clr) begin
               sticky_q <= en ? out : '0;
            end else if (en) begin
               sticky_q <= sticky_q | out;
            end
         end
      end else begin : g_no_sticky
         assign sticky_q = '0;
      end
   endgenerate

endmodule

// File: tb/tb_or_gate.sv
// Self-checking bench for or_gate: directed and random stimulus,
// scoreboard queue popped by a monitor after every rising edge.
module tb_or_gate;

   typedef struct {
      logic [7:0] out;
      logic [7:0] q;
      logic       any;
      logic [7:0] st;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] a, b;
   logic [7:0] out, out_q, sticky_q;
   logic       any_q;
   logic       en, sticky_clr;

   logic       a1, b1;
   logic       out1, out_q1, any_q1, sticky_q1;

   logic       run_clk;
   int         tests  = 0;
   int         failed = 0;
   exp_t       sb[$];

   // reference state: last captured value and every capture since last clear
   logic [7:0] m_q;
   logic       m_any;
   logic [7:0] hist[$];

   or_gate #(.WIDTH(8), .STICKY_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .out(out), .en(en),
      .out_q(out_q), .any_q(any_q), .sticky_clr(sticky_clr), .sticky_q(sticky_q)
   );

   or_gate #(.WIDTH(1), .STICKY_EN(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .out(out1), .en(1'b0),
      .out_q(out_q1), .any_q(any_q1), .sticky_clr(1'b0), .sticky_q(sticky_q1)
   );

   initial begin
      clk = 1'b0;
      wait (run_clk);
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] or_fold();
      logic [7:0] r = 8'h00;
      foreach (hist[i]) r = r | hist[i];
      return r;
   endfunction

   // drive one cycle at the falling edge and queue what the next rising edge must show
   task automatic cycle(input logic r, input logic e, input logic c,
                        input logic [7:0] va, input logic [7:0] vb);
      logic [7:0] v;
      exp_t x;
      @(negedge clk);
      rst_n = r; en = e; sticky_clr = c; a = va; b = vb;
      v = 8'h00;
      for (int unsigned i = 0; i < 8; i++) v[i] = (va[i] == 1'b1) || (vb[i] == 1'b1);
      if (!r) begin
         m_q = 8'h00; m_any = 1'b0; hist.delete();
      end else begin
         if (e) begin
            m_q = v; m_any = (v != 8'h00);
         end
         if (c) hist.delete();
         if (e) hist.push_back(v);
      end
      x.out = v; x.q = m_q; x.any = m_any; x.st = or_fold();
      sb.push_back(x);
   endtask

   always @(posedge clk) begin
      exp_t x;
      #1;
      if (sb.size() > 0) begin
         x = sb.pop_front();
         check("out",      out,             x.out);
         check("out_q",    out_q,           x.q);
         check("any_q",    {7'd0, any_q},   {7'd0, x.any});
         check("sticky_q", sticky_q,        x.st);
      end
   end

   initial begin
      run_clk = 1'b0;
      rst_n = 1'b1; en = 1'b0; sticky_clr = 1'b0; a = 8'h00; b = 8'h00;
      a1 = 1'b0; b1 = 1'b0;

      // combinational, no clock running
      a1 = 0; b1 = 0; #1 check("w1_00", {7'd0, out1}, 8'h00);
      a1 = 0; b1 = 1; #1 check("w1_01", {7'd0, out1}, 8'h01);
      a1 = 1; b1 = 0; #1 check("w1_10", {7'd0, out1}, 8'h01);
      a1 = 1; b1 = 1; #1 check("w1_11", {7'd0, out1}, 8'h01);
      a1 = 1; b1 = 1'bx; #1 check("w1_1x", {7'd0, out1}, 8'h01);
      a = 8'hA0; b = 8'h05; #1 check("w8_a5", out, 8'hA5);
      a = 8'h00; b = 8'h00; #1 check("w8_00", out, 8'h00);
      a = 8'hFF; b = 8'h0F; #1 check("w8_ff", out, 8'hFF);

      run_clk = 1'b1;
      // reset with capture requested
      cycle(0, 1, 0, 8'hFF, 8'h00);
      cycle(0, 1, 0, 8'hFF, 8'h00);
      // register / enable hold
      cycle(1, 1, 0, 8'h10, 8'h01);
      cycle(1, 0, 0, 8'h00, 8'h00);
      // sticky accumulate
      cycle(1, 0, 1, 8'h00, 8'h00);
      cycle(1, 1, 0, 8'h01, 8'h00);
      cycle(1, 1, 0, 8'h00, 8'h20);
      cycle(1, 1, 0, 8'h00, 8'h00);
      cycle(1, 0, 1, 8'h00, 8'h00);
      // clear with load, then reset during capture
      cycle(1, 1, 0, 8'h03, 8'h00);
      cycle(1, 1, 1, 8'h80, 8'h00);
      cycle(0, 1, 0, 8'h5A, 8'h00);

      for (int i = 0; i < 300; i++) begin
         cycle(($urandom_range(0, 19) != 0),
               ($urandom_range(0, 2) != 0),
               ($urandom_range(0, 7) == 0),
               8'($urandom & $urandom), 8'($urandom & $urandom));
      end

      repeat (4) @(posedge clk);
      #2;
      tests++;
      if (sb.size() != 0) begin
         failed++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/or_gate.md
Name: or_gate

Overview:
- Bitwise two-input OR primitive for the gate-level library.
- Its combinational output is the plain OR of the two operands and is valid with no clock activity.
- It also provides a registered copy, a registered reduction flag and a sticky accumulator, so sequential datapaths can reuse the cell without extra glue.
- One clock; reset is synchronous and active-low.

Parameters:
- WIDTH, 1, operand and result bit width (≥1).
- STICKY_EN, 1, 1 = sticky accumulator present; 0 = sticky_q tied to 0.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out  output  WIDTH  combinational a | b
- en  input  1  capture enable for the registered outputs
- out_q  output  WIDTH  registered a | b
- any_q  output  1  registered reduction-OR of (a | b)
- sticky_clr  input  1  synchronous clear of the sticky accumulator
- sticky_q  output  WIDTH  accumulated OR of all captured results since the last clear

Behaviour:
- out = a | b, bitwise, purely combinational.
  - No clock or reset dependence.
  - Settles within the same delta/timestep as an input change.
  - Truth table per bit: 00→0, 01→1, 10→1, 11→1.
- X/Z inputs: a bit at 1 on either operand forces 1; otherwise the result follows standard Verilog | semantics.
- All registers update only on the rising edge of clk.
- Reset (rst_n=0 at a clock edge) has highest priority:
  - out_q = 0, any_q = 0, sticky_q = 0.
  - out is unaffected by reset.
- en=1 at an edge (no reset): out_q ← a|b and any_q ← |(a|b). Latency is 1 cycle from operands to out_q/any_q.
- en=0: out_q and any_q hold.
- Sticky update, when STICKY_EN=1 and there is no reset, in priority order:
  - sticky_clr=1 and en=1: sticky_q ← a|b. Clear and load happen together; the new data is not lost.
  - sticky_clr=1 and en=0: sticky_q ← 0.
  - sticky_clr=0 and en=1: sticky_q ← sticky_q | a | b.
  - Otherwise: sticky_q holds.
- Reset asserted mid-operation discards all accumulated state on that edge. The first capture is the edge after rst_n returns high.
- No internal state beyond out_q, any_q and sticky_q. No wrap-around or overflow is possible; OR is monotonic.
- All outputs are driven at all times; there are no tristates.

Test Plan:
- WIDTH=1, no clock: apply (a,b) = (0,0), (0,1), (1,0), (1,1), waiting 1 time unit after each -> out = 0, 1, 1, 1 respectively.
- WIDTH=8, no clock: a=8'hA0, b=8'h05 -> out=8'hA5. a=8'h00, b=8'h00 -> out=8'h00. a=8'hFF, b=8'h0F -> out=8'hFF.
- Reset: hold rst_n=0 for 2 edges with a=8'hFF, en=1 -> out_q=0, any_q=0, sticky_q=0, while out=8'hFF throughout.
- Register/enable: rst_n=1, en=1, a=8'h10, b=8'h01 at an edge -> out_q=8'h11, any_q=1 after that edge. Then en=0 with a=b=0 -> out_q stays 8'h11 and any_q stays 1, while out=8'h00.
- Sticky accumulate: en=1 over three edges with (a|b) = 8'h01, 8'h20, 8'h00 -> sticky_q = 8'h01, 8'h21, 8'h21. Then sticky_clr=1 with en=0 -> sticky_q=8'h00.
- Simultaneous events:
  - sticky_clr=1 with en=1 and a|b=8'h80 -> sticky_q=8'h80 (clear-then-load).
  - rst_n=0 with en=1 and sticky_clr=0 -> all registers 0.
